// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one outstanding doubleword access
// held until mem_ack.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian load/store unit: decodes one access, drives the memory bus until
// ack or timeout, then writes load results back to the register file.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [5:0]               opcode,
    input  logic [63:0]              addr,
    input  logic [63:0]              store_data,
    input  logic [4:0]               dest_reg,
    output logic                     busy,
    load_store_unit_if.master        mem,
    output logic                     wb_valid,
    output logic [4:0]               wb_reg,
    output logic [63:0]              wb_data,
    output logic                     err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;

    // sz is log2 of the access size in bytes
    typedef struct packed {
        logic       legal;
        logic       store;
        logic       sign;
        logic [1:0] sz;
    } op_t;

    function automatic op_t decode(input logic [5:0] op);
        op_t d;
        d = '0;
        case (op)
            6'd34:   d = {1'b1, 1'b0, 1'b0, 2'd0};
            6'd40:   d = {1'b1, 1'b0, 1'b0, 2'd1};
            6'd42:   d = {1'b1, 1'b0, 1'b1, 2'd1};
            6'd32:   d = {1'b1, 1'b0, 1'b0, 2'd2};
            6'd58:   d = {1'b1, 1'b0, 1'b0, 2'd3};
            6'd38:   d = {1'b1, 1'b1, 1'b0, 2'd0};
            6'd44:   d = {1'b1, 1'b1, 1'b0, 2'd1};
            6'd36:   d = {1'b1, 1'b1, 1'b0, 2'd2};
            6'd62:   d = {1'b1, 1'b1, 1'b0, 2'd3};
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t      state, state_nxt;
    logic [CW-1:0] cnt;
    op_t         dec;
    logic        misalign, accept;
    logic [2:0]  shamt;
    logic [7:0]  size_mask;

    logic [63:0] addr_q, wdata_q;
    logic [7:0]  be_q;
    logic        store_q, sign_q;
    logic [1:0]  sz_q;
    logic [2:0]  shamt_q;
    logic [4:0]  dest_q;
    logic [63:0] rshift, load_val;

    always_comb begin
        dec = decode(opcode);
        misalign = 1'b0;
        size_mask = 8'h01;
        case (dec.sz)
            2'd0: begin misalign = 1'b0;        size_mask = 8'h01; end
            2'd1: begin misalign = addr[0];     size_mask = 8'h03; end
            2'd2: begin misalign = |addr[1:0];  size_mask = 8'h0F; end
            default: begin misalign = |addr[2:0]; size_mask = 8'hFF; end
        endcase
        // Lane distance (in bytes) from the LSB of the doubleword to the end of the access
        shamt = 3'(4'd8 - (4'd1 << dec.sz) - {1'b0, addr[2:0]});
        accept = (state == IDLE) && start && dec.legal && !misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            store_q <= 1'b0;
            sign_q  <= 1'b0;
            sz_q    <= '0;
            shamt_q <= '0;
            dest_q  <= '0;
        end else if (accept) begin
            addr_q  <= {addr[63:3], 3'b000};
            wdata_q <= store_data << {shamt, 3'b000};
            be_q    <= dec.store ? (size_mask << shamt) : 8'h00;
            store_q <= dec.store;
            sign_q  <= dec.sign;
            sz_q    <= dec.sz;
            shamt_q <= shamt;
            dest_q  <= dest_reg;
        end
    end

    always_comb begin
        rshift = mem.mem_rdata >> {shamt_q, 3'b000};
        case (sz_q)
            2'd0:    load_val = {56'b0, rshift[7:0]};
            2'd1:    load_val = {{48{sign_q & rshift[15]}}, rshift[15:0]};
            2'd2:    load_val = {32'b0, rshift[31:0]};
            default: load_val = rshift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg  <= '0;
            wb_data <= '0;
        end else if (state == REQ && mem.mem_ack && !store_q) begin
            wb_reg  <= dest_q;
            wb_data <= load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (state != REQ)  cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (dec.legal && !misalign) ? REQ : ERR;
            REQ: begin
                if (mem.mem_ack)                  state_nxt = store_q ? IDLE : WB;
                else if (cnt == CW'(TIMEOUT - 1)) state_nxt = ERR;
            end
            WB:      state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign wb_valid      = (state == WB);
    assign err           = (state == ERR);
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = (state == REQ) && store_q;
    assign mem.mem_be    = (state == REQ) ? be_q : 8'h00;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: the driver pushes expected
// bus/write-back/error events, a negedge monitor pops and compares them.
module tb_load_store_unit;
    localparam int TO = 4;
    localparam int K_MEM = 0, K_WB = 1, K_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [63:0] addr = '0, store_data = '0;
    logic [4:0]  dest_reg = '0;
    logic        busy, wb_valid, err;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;

    load_store_unit_if mif();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .addr(addr),
        .store_data(store_data), .dest_reg(dest_reg), .busy(busy), .mem(mif),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        logic        we;
        logic [4:0]  r;
    } ev_t;

    ev_t sbq[$];
    int  nchk = 0, nfail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            6'd34, 6'd38:        return 1;
            6'd40, 6'd42, 6'd44: return 2;
            6'd32, 6'd36:        return 4;
            6'd58, 6'd62:        return 8;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == 6'd38) || (op == 6'd44) || (op == 6'd36) || (op == 6'd62);
    endfunction

    // Reference model: byte-level big-endian memory semantics
    task automatic access(input logic [5:0] op, input logic [63:0] ad, input logic [63:0] sd,
                          input logic [4:0] dr, input logic [63:0] rd,
                          input int delay, input int glitch);
        int          sz = op_size(op);
        bit          st = op_store(op);
        int          k = int'(ad[2:0]);
        bit          ok;
        ev_t         e;
        logic [63:0] v;
        int          n;
        ok = (sz != 0) && ((k % ((sz == 0) ? 1 : sz)) == 0);
        if (!ok) begin
            e = '{K_ERR, 0, 0, 0, 0, 0};
            sbq.push_back(e);
        end else begin
            e = '{K_MEM, {ad[63:3], 3'b000}, 0, 0, st, 0};
            if (st)
                for (int j = 0; j < sz; j++) begin
                    e.be[7-(k+j)] = 1'b1;
                    e.d[63-8*(k+j) -: 8] = sd[8*(sz-1-j) +: 8];
                end
            if (delay < TO) sbq.push_back(e);
            if (!st && delay < TO) begin
                v = 0;
                for (int j = 0; j < sz; j++) v = (v << 8) | 64'(rd[63-8*(k+j) -: 8]);
                if (op == 6'd42 && v[15]) v = v | 64'hFFFF_FFFF_FFFF_0000;
                e = '{K_WB, 0, v, 0, 0, dr};
                sbq.push_back(e);
            end
            if (delay >= TO) begin
                e = '{K_ERR, 0, 0, 0, 0, 0};
                sbq.push_back(e);
            end
        end

        start = 1'b1; opcode = op; addr = ad; store_data = sd; dest_reg = dr;
        @(posedge clk); #1;
        // Scramble inputs after the accepting edge: the DUT must use its latched copies
        start = 1'b0; opcode = 6'($urandom); addr = {$urandom, $urandom};
        store_data = {$urandom, $urandom}; dest_reg = 5'($urandom);
        if (!ok) begin
            chk("err_after_start", err, 1);
            chk("no_req_on_err", mif.mem_req, 0);
            @(posedge clk); #1;
            chk("idle_after_err", busy, 0);
            return;
        end
        for (int i = 0; i < TO; i++) begin
            chk("req_held", mif.mem_req, 1);
            chk("addr_held", mif.mem_addr, {ad[63:3], 3'b000});
            chk("we_held", mif.mem_we, st);
            chk("no_early_wb", wb_valid, 0);
            mif.mem_rdata = {$urandom, $urandom};
            if (i == delay) begin
                mif.mem_ack = 1'b1;
                mif.mem_rdata = rd;
            end
            if (i == glitch) begin
                start = 1'b1; opcode = 6'd58; addr = 64'h0000_0000_0000_7700; dest_reg = ~dr;
            end
            @(posedge clk); #1;
            mif.mem_ack = 1'b0;
            start = 1'b0;
            if (i == delay) break;
        end
        if (delay >= TO) begin
            chk("timeout_err", err, 1);
            chk("timeout_req_drop", mif.mem_req, 0);
        end else if (!st) chk("wb_latency", wb_valid, 1);
        else chk("store_done", busy, 0);
        n = 0;
        while (busy && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk("return_idle", busy, 0);
    endtask

    // Scoreboard monitor
    logic [63:0] last_d = '0;
    logic [4:0]  last_r = '0;

    task automatic pop(input int kind, output ev_t e, output bit got);
        got = 1'b0;
        e = '{0, 0, 0, 0, 0, 0};
        if (sbq.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sbq.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            got = 1'b1;
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t         e;
        bit          got;
        logic [63:0] m;
        if (!rst_n) begin
            last_d = '0;
            last_r = '0;
        end else begin
            if (mif.mem_req && mif.mem_ack) begin
                pop(K_MEM, e, got);
                if (got) begin
                    chk("mem_addr", mif.mem_addr, e.a);
                    chk("mem_we", mif.mem_we, e.we);
                    if (e.we) begin
                        m = '0;
                        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{mif.mem_be[b]}};
                        chk("mem_be", mif.mem_be, e.be);
                        chk("mem_wdata", mif.mem_wdata & m, e.d);
                    end
                end
            end
            if (wb_valid) begin
                pop(K_WB, e, got);
                if (got) begin
                    chk("wb_reg", wb_reg, e.r);
                    chk("wb_data", wb_data, e.d);
                end
                last_d = wb_data;
                last_r = wb_reg;
            end else begin
                chk("wb_data_hold", wb_data, last_d);
                chk("wb_reg_hold", wb_reg, last_r);
            end
            if (err) pop(K_ERR, e, got);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [5:0]  ops [9] = '{6'd34, 6'd40, 6'd42, 6'd32, 6'd58, 6'd38, 6'd44, 6'd36, 6'd62};
        logic [5:0]  op;
        logic [63:0] ad;
        int          sz;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_we", mif.mem_we, 0);
        chk("rst_be", mif.mem_be, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_reg", wb_reg, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases; start issued in the first cycle after reset release
        access(6'd42, 64'h1006, 64'h1234, 5'd7, 64'h0000_0000_0000_8001, 3, -1);
        access(6'd38, 64'h2003, 64'hAB, 5'd1, 64'h0, 0, -1);
        access(6'd32, 64'h3002, 64'h0, 5'd2, 64'h0, 0, -1);
        access(6'd7, 64'h3000, 64'h0, 5'd2, 64'h0, 0, -1);
        access(6'd58, 64'h4000, 64'h0, 5'd4, 64'h0, 99, -1);
        access(6'd32, 64'h5004, 64'h0, 5'd9, 64'h0123_4567_89AB_CDEF, 2, 1);
        access(6'd62, 64'h6000, 64'hFEDC_BA98_7654_3210, 5'd0, 64'h0, 1, 0);
        access(6'd58, 64'h6008, 64'h0, 5'd31, 64'hFEDC_BA98_7654_3210, 0, -1);

        // Reset in the middle of a request; no expectations are pushed for it
        start = 1'b1; opcode = 6'd58; addr = 64'h8000; dest_reg = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", mif.mem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_wdata", mif.mem_wdata, 0);
        chk("midrst_addr", mif.mem_addr, 0);
        chk("midrst_wb_data", wb_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.mem_ack = 1'b1;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_stays_idle", busy, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(6'd40, 64'h9002, 64'h0, 5'd12, 64'h0000_BEEF_0000_0000, 0, -1);

        for (int t = 0; t < 300; t++) begin
            op = (t % 10 == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            ad = {$urandom, $urandom};
            sz = op_size(op);
            if ($urandom_range(0, 3) != 0 && sz > 0) ad = ad & ~64'(sz - 1);
            access(op, ad, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
                   $urandom_range(0, TO + 1), $urandom_range(0, TO));
            if ($urandom_range(0, 4) == 0) begin
                mif.mem_ack = 1'b1;
                @(posedge clk); #1;
                mif.mem_ack = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum cycles mem_req is held without mem_ack before the access aborts.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse requesting an access; sampled only in IDLE.
REQ-005 opcode  input  6  access type: 34 lbz, 40 lhz, 42 lha, 32 lwz, 58 ld, 38 stb, 44 sth, 36 stw, 62 std.
REQ-006 addr  input  64  byte effective address.
REQ-007 store_data  input  64  store source (register-file read_data_2); low bytes used for stb/sth/stw.
REQ-008 dest_reg  input  5  load destination register number.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 mem_req / mem_we  output  1 each  memory request and write enable.
REQ-011 mem_addr  output  64  doubleword-aligned address (addr with bits [2:0] cleared).
REQ-012 mem_wdata / mem_be  output  64 / 8  write data and byte enables; be[7] selects byte lane [63:56].
REQ-013 mem_ack / mem_rdata  input  1 / 64  memory completion and read data.
REQ-014 wb_valid / wb_reg / wb_data  output  1 / 5 / 64  register-file write-back strobe, register number, data.
REQ-015 err  output  1  one-cycle pulse: misalignment, illegal opcode, or timeout.

Function
REQ-016 Byte order is big-endian; byte offset k = addr[2:0] occupies lane [63-8k:56-8k].
REQ-017 FSM states: IDLE, REQ, WB, ERR; encoding is free.
REQ-018 IDLE + start, legal opcode, aligned -> REQ; opcode, addr, store_data, dest_reg are latched on that edge.
REQ-019 IDLE + start with illegal opcode or misalignment -> ERR; no memory request is issued.
REQ-020 Alignment: halfword requires addr[0]=0, word requires addr[1:0]=0, doubleword requires addr[2:0]=0; byte accesses are always aligned.
REQ-021 In REQ: mem_req=1 and mem_addr, mem_we, mem_be, mem_wdata are held stable until the cycle mem_ack=1.
REQ-022 Store byte enables: stb = 1 bit at k; sth = 2 bits from k; stw = 4 bits from k; std = 8'hFF.
REQ-023 Store write data: the source bytes are replicated or shifted into the enabled lanes; other lanes are don't-care.
REQ-024 REQ + mem_ack with a load -> WB; REQ + mem_ack with a store -> IDLE.
REQ-025 Load extraction from latched mem_rdata: lbz zero-extends 8 bits, lhz zero-extends 16, lha sign-extends 16, lwz zero-extends 32, ld passes all 64.
REQ-026 In WB: wb_valid=1 for exactly one cycle with wb_reg=latched dest_reg and wb_data=extracted value -> IDLE.
REQ-027 Latency: start at cycle 0, mem_req from cycle 1; ack at cycle n gives wb_valid at cycle n+1; minimum start-to-wb_valid is 2 cycles.
REQ-028 A wait counter clears on entry to REQ; if it reaches TIMEOUT with no ack -> ERR and mem_req drops.
REQ-029 ERR: err=1 for one cycle -> IDLE; wb_valid stays 0.
REQ-030 start while busy is ignored; it is neither queued nor allowed to corrupt latched fields.
REQ-031 mem_ack outside REQ is ignored.
REQ-032 wb_data and wb_reg hold their last values when wb_valid=0.

Reset
REQ-033 rst_n low at any time, including mid-access, forces IDLE immediately, clears the wait counter, and drives busy, mem_req, mem_we, mem_be, wb_valid, err to 0 and mem_addr, mem_wdata, wb_reg, wb_data to 0.
REQ-034 After reset release, the first start is accepted in the first cycle rst_n is sampled high.

Verification
REQ-035 lha, addr=0x1006, mem_rdata=0x0000_0000_0000_8001, ack after 3 cycles -> mem_addr=0x1000, wb_data=0xFFFF_FFFF_FFFF_8001, wb_valid 4 cycles after mem_req rises.
REQ-036 stb, addr=0x2003, store_data=0xAB -> mem_be=8'b0001_0000, mem_wdata[39:32]=0xAB, mem_we=1, no wb_valid.
REQ-037 lwz, addr=0x3002 -> err pulse the cycle after start, mem_req never asserted; opcode 7 behaves the same.
REQ-038 ld, mem_ack never asserted, TIMEOUT=4 -> mem_req high for 4 cycles, then err pulse and return to IDLE.
REQ-039 rst_n low during REQ -> mem_req and busy drop asynchronously; a later mem_ack produces no wb_valid.
REQ-040 start asserted during REQ with a different dest_reg -> the original dest_reg is written back and the second request is dropped.
